// File: rtl/scan_pkg.sv
// Shared definitions for the 8-digit active-low scan bus (capture side and scan mux).
package scan_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SEL_W      = NUM_DIGITS;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
  localparam int unsigned FRAME_W    = NUM_DIGITS * DIGIT_W;

  localparam logic [SEL_W-1:0] SEL_IDLE = 8'hFF;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_e;

  // Digit i occupies bits [4i+3:4i] when flattened.
  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

endpackage

// File: rtl/onehot_low_decode.sv
// Classifies an active-low select word as idle, single (with index) or multiple.
module onehot_low_decode
  import scan_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  output logic             is_idle,
  output logic             is_valid,
  output logic             is_multi,
  output logic [IDX_W-1:0] idx
);

  localparam int unsigned ZCNT_W = $clog2(NUM_DIGITS + 1);

  logic [ZCNT_W-1:0] zero_cnt;

  always_comb begin
    zero_cnt = '0;
    idx      = '0;
    for (int i = 0; i < SEL_W; i++) begin
      if (!sel[i]) begin
        zero_cnt = zero_cnt + ZCNT_W'(1);
        idx      = IDX_W'(i);
      end
    end
    is_idle  = (zero_cnt == ZCNT_W'(0));
    is_valid = (zero_cnt == ZCNT_W'(1));
    is_multi = (zero_cnt >  ZCNT_W'(1));
  end

endmodule

// File: rtl/scan_digit_capture.sv
// Rebuilds 8-digit frames from a time-multiplexed active-low scan bus and
// publishes each complete, in-order frame atomically.
module scan_digit_capture
  import scan_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEL_W-1:0]   selmo,
  input  logic [DIGIT_W-1:0] outm,
  output logic [FRAME_W-1:0] frame_digits,
  output logic               frame_done,
  output logic [7:0]         frame_cnt,
  output logic               sel_err,
  output logic               seq_err,
  output logic               stale,
  output logic               locked
);

  localparam int unsigned     FCNT_W   = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DIGIT_W-1:0]  val_q, val_d;
  digits_t             work_q, work_d;
  digits_t             frame_digits_q, frame_digits_d;
  logic [IDX_W-1:0]    prev_idx_q, prev_idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                frame_done_q, frame_done_d;
  logic                sel_err_q, sel_err_d;
  logic                seq_err_q, seq_err_d;
  logic                stale_q, stale_d;

  logic                dec_idle, dec_valid, dec_multi;
  logic [IDX_W-1:0]    dec_idx;
  logic [IDX_W-1:0]    next_idx;
  logic                in_order, idx_change, cnt_expired;
  logic                ev_sel_err, ev_seq_err, ev_stale, cap_en;

  onehot_low_decode u_decode (
    .sel      (sel_q),
    .is_idle  (dec_idle),
    .is_valid (dec_valid),
    .is_multi (dec_multi),
    .idx      (dec_idx)
  );

  assign next_idx    = prev_idx_q + IDX_W'(1);
  assign in_order    = dec_valid && ((dec_idx == prev_idx_q) || (dec_idx == next_idx));
  assign idx_change  = dec_valid && (dec_idx != prev_idx_q);
  assign cnt_expired = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  // Event priority: multi-select, then sequence error, then timeout, then capture.
  always_comb begin
    state_d    = state_q;
    ev_sel_err = 1'b0;
    ev_seq_err = 1'b0;
    ev_stale   = 1'b0;
    cap_en     = 1'b0;
    if (dec_multi) begin
      ev_sel_err = 1'b1;
      state_d    = HUNT;
    end else if (state_q == HUNT) begin
      if (dec_valid && (dec_idx == '0)) begin
        cap_en  = 1'b1;
        state_d = TRACK;
      end
    end else if (dec_valid && !in_order) begin
      ev_seq_err = 1'b1;
      if (dec_idx == '0) begin
        cap_en  = 1'b1;
        state_d = TRACK;
      end else begin
        state_d = HUNT;
      end
    end else if (!idx_change && cnt_expired) begin
      ev_stale = 1'b1;
      state_d  = HUNT;
    end else if (!dec_idle) begin
      cap_en = 1'b1;
    end
  end

  always_comb begin
    sel_d          = selmo;
    val_d          = outm;
    work_d         = work_q;
    prev_idx_d     = prev_idx_q;
    frame_digits_d = frame_digits_q;
    frame_cnt_d    = frame_cnt_q;
    frame_done_d   = 1'b0;
    sel_err_d      = ev_sel_err;
    seq_err_d      = ev_seq_err;
    stale_d        = ev_stale;
    cnt_d          = '0;
    if (cap_en) begin
      work_d[dec_idx] = val_q;
      prev_idx_d      = dec_idx;
    end
    // A capture of the last digit that advanced the index completes a frame.
    if (cap_en && idx_change && (dec_idx == LAST_IDX)) begin
      frame_digits_d = work_d;
      frame_cnt_d    = frame_cnt_q + FCNT_W'(1);
      frame_done_d   = 1'b1;
    end
    if ((state_q == TRACK) && (state_d == TRACK) && !idx_change) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q          <= SEL_IDLE;
      val_q          <= '0;
      work_q         <= '0;
      prev_idx_q     <= '0;
      cnt_q          <= '0;
      frame_digits_q <= '0;
      frame_cnt_q    <= '0;
      frame_done_q   <= 1'b0;
      sel_err_q      <= 1'b0;
      seq_err_q      <= 1'b0;
      stale_q        <= 1'b0;
    end else begin
      sel_q          <= sel_d;
      val_q          <= val_d;
      work_q         <= work_d;
      prev_idx_q     <= prev_idx_d;
      cnt_q          <= cnt_d;
      frame_digits_q <= frame_digits_d;
      frame_cnt_q    <= frame_cnt_d;
      frame_done_q   <= frame_done_d;
      sel_err_q      <= sel_err_d;
      seq_err_q      <= seq_err_d;
      stale_q        <= stale_d;
    end
  end

  assign frame_digits = frame_digits_q;
  assign frame_done   = frame_done_q;
  assign frame_cnt    = frame_cnt_q;
  assign sel_err      = sel_err_q;
  assign seq_err      = seq_err_q;
  assign stale        = stale_q;
  assign locked       = (state_q == TRACK);

endmodule

// File: tb/tb_scan_digit_capture.sv
// Directed bench for scan_digit_capture with a short timeout.
module tb_scan_digit_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  selmo;
  logic [3:0]  outm;
  logic [31:0] frame_digits;
  logic        frame_done;
  logic [7:0]  frame_cnt;
  logic        sel_err;
  logic        seq_err;
  logic        stale;
  logic        locked;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_sel    = 0;
  int n_seq    = 0;
  int n_stale  = 0;
  logic [7:0] last_done_cnt = 8'hAA;

  scan_digit_capture #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .selmo        (selmo),
    .outm         (outm),
    .frame_digits (frame_digits),
    .frame_done   (frame_done),
    .frame_cnt    (frame_cnt),
    .sel_err      (sel_err),
    .seq_err      (seq_err),
    .stale        (stale),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (frame_done) begin
      n_done++;
      last_done_cnt = frame_cnt;
    end
    if (sel_err) n_sel++;
    if (seq_err) n_seq++;
    if (stale)   n_stale++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] sel, input logic [3:0] val);
    @(negedge clk);
    selmo = sel;
    outm  = val;
  endtask

  task automatic drive_digit(input int idx, input logic [3:0] val);
    logic [7:0] s;
    s = ~(8'h01 << idx);
    drive(s, val);
  endtask

  task automatic clear_counts();
    n_done  = 0;
    n_sel   = 0;
    n_seq   = 0;
    n_stale = 0;
  endtask

  task automatic clean_frame(input logic [3:0] base);
    for (int i = 0; i < 8; i++) drive_digit(i, 4'(base + 4'(i)));
  endtask

  initial begin
    rst   = 1'b1;
    selmo = 8'hFF;
    outm  = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_digits", frame_digits, 32'h0);
    check("rst_cnt", 32'(frame_cnt), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_done", 32'(frame_done), 32'h0);
    rst = 1'b0;
    clear_counts();

    // Clean scan with latency check.
    for (int i = 0; i < 8; i++) drive_digit(i, 4'(i + 1));
    drive(8'hFF, 4'h0);
    check("lat_done_early", 32'(frame_done), 32'h0);
    check("lat_digits_early", frame_digits, 32'h0);
    drive(8'hFF, 4'h0);
    check("clean_done", 32'(frame_done), 32'h1);
    check("clean_digits", frame_digits, 32'h87654321);
    check("clean_cnt", 32'(frame_cnt), 32'd1);
    check("clean_locked", 32'(locked), 32'h1);
    drive(8'hFF, 4'h0);
    check("clean_done_once", 32'(n_done), 32'd1);
    clear_counts();

    // Stretched scan with blanking gaps.
    for (int i = 0; i < 8; i++) begin
      repeat (3) drive_digit(i, 4'(9 - i));
      drive(8'hFF, 4'h0);
    end
    drive(8'hFF, 4'h0);
    check("stretch_digits", frame_digits, 32'h23456789);
    check("stretch_errs", 32'(n_sel + n_seq + n_stale), 32'd0);
    check("stretch_done", 32'(n_done), 32'd1);
    check("stretch_cnt", 32'(frame_cnt), 32'd2);
    clear_counts();

    // Skipped digit.
    drive_digit(0, 4'hA);
    drive_digit(1, 4'hB);
    drive_digit(3, 4'hC);
    repeat (3) drive(8'hFF, 4'h0);
    check("skip_seq", 32'(n_seq), 32'd1);
    check("skip_locked", 32'(locked), 32'h0);
    check("skip_cnt", 32'(frame_cnt), 32'd2);
    check("skip_digits", frame_digits, 32'h23456789);
    check("skip_done", 32'(n_done), 32'd0);
    clean_frame(4'h5);
    repeat (2) drive(8'hFF, 4'h0);
    check("skip_recover_digits", frame_digits, 32'hCBA98765);
    check("skip_recover_cnt", 32'(frame_cnt), 32'd3);
    check("skip_recover_done", 32'(n_done), 32'd1);
    clear_counts();

    // Multi-select mid-frame.
    drive_digit(0, 4'h1);
    drive_digit(1, 4'h2);
    drive_digit(2, 4'h3);
    drive(8'hFC, 4'h4);
    for (int i = 3; i < 8; i++) drive_digit(i, 4'(i));
    repeat (2) drive(8'hFF, 4'h0);
    check("multi_sel", 32'(n_sel), 32'd1);
    check("multi_seq", 32'(n_seq), 32'd0);
    check("multi_done", 32'(n_done), 32'd0);
    check("multi_locked", 32'(locked), 32'h0);
    check("multi_cnt", 32'(frame_cnt), 32'd3);
    clear_counts();

    // Timeout while a select is held.
    drive_digit(0, 4'hE);
    drive_digit(1, 4'hD);
    repeat (10) drive(8'hFB, 4'h7);
    check("to_locked_early", 32'(locked), 32'h1);
    check("to_stale_early", 32'(n_stale), 32'd0);
    repeat (10) drive(8'hFB, 4'h7);
    repeat (3) drive(8'hFF, 4'h0);
    check("to_stale", 32'(n_stale), 32'd1);
    check("to_locked", 32'(locked), 32'h0);
    check("to_digits", frame_digits, 32'hCBA98765);
    check("to_seq", 32'(n_seq), 32'd0);
    clear_counts();

    // Reset mid-frame, then wrap the frame counter.
    drive_digit(0, 4'h1);
    drive_digit(1, 4'h2);
    drive_digit(2, 4'h3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_digits", frame_digits, 32'h0);
    check("midrst_cnt", 32'(frame_cnt), 32'd0);
    check("midrst_locked", 32'(locked), 32'h0);
    check("midrst_pulses", 32'({frame_done, sel_err, seq_err, stale}), 32'h0);
    rst = 1'b0;
    drive(8'hFF, 4'h0);
    clear_counts();
    for (int f = 0; f < 256; f++) clean_frame(4'(f));
    repeat (2) drive(8'hFF, 4'h0);
    check("wrap_done", 32'(n_done), 32'd256);
    check("wrap_cnt", 32'(frame_cnt), 32'd0);
    check("wrap_last_pulse_cnt", 32'(last_done_cnt), 32'd0);
    check("wrap_digits", frame_digits, 32'h6543210F);
    check("wrap_errs", 32'(n_sel + n_seq + n_stale), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/scan_digit_capture.md
Name: scan_digit_capture

Overview:
- Receiving end of the 8-digit time-multiplexed display scan bus: active-low one-hot digit select plus 4-bit digit value.
- Decodes the scan stream and rebuilds the 8 digit values as parallel registers.
- Publishes a complete frame atomically once all 8 digits arrive in order.
- Uses: loopback checking of the display path on board, and capture of scan buses from other boards into the datapath.

Parameters:
- TIMEOUT, 1024: clocks without a valid select change before the stream is declared stale.
- CNT_W, 11: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- selmo  input  8  scan select, active-low one-hot; bit i low selects digit i.
- outm  input  4  digit value belonging to the current select.
- frame_digits  output  32  last complete frame; digit i at bits [4i+3:4i].
- frame_done  output  1  one-clock pulse when frame_digits updates.
- frame_cnt  output  8  count of completed frames; wraps 255->0.
- sel_err  output  1  one-clock pulse: select has more than one low bit.
- seq_err  output  1  one-clock pulse: out-of-order digit index.
- stale  output  1  one-clock pulse: TIMEOUT expired.
- locked  output  1  high while the block is in state TRACK.

Behaviour:
- Reset: synchronous, active-high; the only reset. On reset, all outputs = 0, input registers = 8'hFF / 4'h0, work buffer = 0, state HUNT, timeout counter = 0.
- Input stage:
  - selmo and outm are registered together each clock (sel_q, val_q).
  - The decode stage acts on sel_q/val_q at the next edge.
  - Pin-to-frame_digits latency = 2 clocks after the digit-7 sample.
- Decode classes for sel_q:
  - IDLE: all ones.
  - VALID(i): exactly one zero, at bit i.
  - MULTI: two or more zeros.
- States:
  - HUNT: ignore everything except VALID(0). On VALID(0): work[0] <= val_q, prev_idx <= 0, go to TRACK.
  - TRACK, VALID(i) with i == prev_idx: stretched scan. Rewrite work[i] <= val_q; no error.
  - TRACK, VALID(i) with i == prev_idx+1 (mod 8): work[i] <= val_q, prev_idx <= i.
    - If i == 7: frame_digits <= work with digit 7 replaced by val_q (same edge), frame_done = 1, frame_cnt += 1. Stay in TRACK, expecting 0 next.
    - VALID(0) after 7 starts the next frame.
  - TRACK, VALID(i) with any other i: seq_err pulse, go to HUNT, frame not published.
    - If that i is 0, the HUNT entry is taken on the same edge: work[0] written, go to TRACK, seq_err still pulses.
  - Any state, MULTI: sel_err pulse, go to HUNT, no buffer write.
  - IDLE: no write, no state change (blanking gap is legal).
- Timeout:
  - Counter clears on every edge where the decoded index differs from the previous valid index, and on entry to TRACK.
  - Otherwise it increments, but only in TRACK.
  - When it reaches TIMEOUT-1: stale pulse, go to HUNT, counter = 0.
  - frame_digits keeps its last value; it is never cleared except by reset.
- Simultaneous events, in priority order: rst > sel_err > seq_err > stale > normal capture. At most one error pulse per clock.
- Reset mid-frame: the partial work buffer is discarded and frame_cnt = 0.
- The work buffer is not cleared on error; every published frame is fully rewritten by digits 0..7 in order before publication.

Decomposition:
- Shared package scan_pkg:
  - NUM_DIGITS = 8, DIGIT_W = 4.
  - State encoding HUNT = 1'b0, TRACK = 1'b1.
  - SEL_IDLE = 8'hFF.
- The same package is used by the display scan multiplexer.
- Sub-module onehot_low_decode: takes the 8-bit active-low select; returns is_idle, is_valid, is_multi and a 3-bit index. Purely combinational.
- Everything else stays flat in scan_digit_capture.

Test Plan:
- Clean scan:
  - Stimulus: after rst, drive selmo = 8'hFE..8'h7F with outm = 1..8, one per clock.
  - Required: frame_digits = 32'h87654321, frame_done pulses once 2 clocks after the last sample, frame_cnt = 1, locked = 1.
- Stretched and blanked scan:
  - Stimulus: each select held 3 clocks with 8'hFF gaps between digits; values 9,8,...,2.
  - Required: frame_digits = 32'h23456789, no error pulses.
- Skip:
  - Stimulus: digits 0,1,3 in sequence.
  - Required: seq_err one pulse, locked drops, frame_cnt unchanged, frame_digits unchanged.
  - Follow-up: a clean frame then publishes normally.
- Multi-select:
  - Stimulus: selmo = 8'hFC mid-frame.
  - Required: sel_err pulse, return to HUNT, no frame_done for that frame.
- Timeout:
  - Stimulus: TIMEOUT = 16; hold selmo = 8'hFB for 20 clocks in TRACK.
  - Required: stale pulses exactly once, locked = 0, frame_digits retained.
- Reset and wrap:
  - Stimulus: assert rst mid-frame.
  - Required: all outputs 0 on the next clock.
  - Follow-up: run 256 clean frames; frame_cnt wraps to 0 with frame_done still pulsing.
